// File: rtl/ci_adc_framer_pkg.sv
// rtl/ci_adc_framer_pkg.sv - shared constants, FSM states and helpers for ci_adc_framer
// The Hann coefficient helper exists only when CI_FRAMER_WINDOW_EN is defined.
package ci_adc_framer_pkg;

  localparam int DATLEN     = 12;
  localparam int VLEN       = 16;
  localparam int VLEN_LOG2  = 4;
  localparam int FIFO_DEPTH = 4;

  localparam logic [DATLEN-1:0] ADC_MIDSCALE = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Offset-binary to two's complement is a flip of the MSB.
  function automatic logic [DATLEN-1:0] adc_to_signed(input logic [DATLEN-1:0] s);
    return s ^ ADC_MIDSCALE;
  endfunction

`ifdef CI_FRAMER_WINDOW_EN
  // Periodic 16-point Hann, unsigned Q1.11, peak 1.0 at index 8.
  function automatic logic [DATLEN-1:0] hann_coef(input logic [VLEN_LOG2-1:0] i);
    case (i)
      4'd0:          return 12'h000;
      4'd1,  4'd15:  return 12'h04E;
      4'd2,  4'd14:  return 12'h12C;
      4'd3,  4'd13:  return 12'h278;
      4'd4,  4'd12:  return 12'h400;
      4'd5,  4'd11:  return 12'h588;
      4'd6,  4'd10:  return 12'h6D4;
      4'd7,  4'd9:   return 12'h7B2;
      default:       return 12'h800;
    endcase
  endfunction
`endif

endpackage

// File: rtl/ci_sync_fifo.sv
// rtl/ci_sync_fifo.sv - small synchronous FIFO with flush, used as the ADC input buffer
module ci_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ci_adc_framer.sv
// rtl/ci_adc_framer.sv - ADC sample framer feeding the FFT with spaced fft_nd strobes
// Define CI_FRAMER_WINDOW_EN to apply a Hann window (adds one output pipeline stage).
module ci_adc_framer
  import ci_adc_framer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 adc_valid,
  input  logic [DATLEN-1:0]    adc_data,
  output logic                 adc_ready,
  output logic [0:2*DATLEN-1]  fft_x,
  output logic                 fft_nd,
  output logic                 frame_start,
  output logic [VLEN_LOG2-1:0] frame_idx,
  output logic                 drop_flag
);

  state_t state, state_nxt;

  logic                 alive, draining, start_drain, drain_last;
  logic                 full, empty, push, pop, flush, load;
  logic [DATLEN-1:0]    head;
  logic [VLEN_LOG2-1:0] cnt;
  logic                 iss_nd, iss_start;
  logic [DATLEN-1:0]    iss_re;
  logic [VLEN_LOG2-1:0] iss_idx;
  logic                 out_nd, out_start;
  logic [DATLEN-1:0]    out_re;
  logic [VLEN_LOG2-1:0] out_idx;

  // alive keeps adc_ready low while reset is asserted even if run is already high.
  assign adc_ready   = alive & run & ~full & ~draining;
  assign push        = adc_valid & adc_ready;
  assign start_drain = ~run & ~draining & (cnt != '0);
  assign drain_last  = load & draining & (cnt == VLEN_LOG2'(VLEN - 1));
  assign flush       = (~run & ~draining & (cnt == '0)) | drain_last;

  ci_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATLEN)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (adc_to_signed(adc_data)),
    .rdata   (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_GAP: state_nxt = ((~empty & run) | draining) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:        state_nxt = ST_GAP;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  // The issued word is captured on entry to ISSUE so fft_nd and fft_x line up.
  always_comb begin
    iss_nd = (state == ST_ISSUE);
    load   = (state_nxt == ST_ISSUE);
    pop    = load & ~empty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alive     <= 1'b0;
      draining  <= 1'b0;
      drop_flag <= 1'b0;
      cnt       <= '0;
      iss_re    <= '0;
      iss_idx   <= '0;
      iss_start <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (adc_valid && !adc_ready) drop_flag <= 1'b1;
      if (start_drain)     draining <= 1'b1;
      else if (drain_last) draining <= 1'b0;
      if (load) begin
        iss_re    <= pop ? head : '0;
        iss_idx   <= cnt;
        iss_start <= (cnt == '0);
        cnt       <= cnt + VLEN_LOG2'(1);
      end
    end
  end

`ifdef CI_FRAMER_WINDOW_EN
  localparam int PW = 2*DATLEN + 1;
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2**(DATLEN-1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2**(DATLEN-1)));

  logic [DATLEN:0]        coef;
  logic signed [PW-1:0]   prod, rnd, shifted;
  logic [DATLEN-1:0]      win_re;

  always_comb begin
    coef    = {1'b0, hann_coef(iss_idx)};
    prod    = PW'($signed(iss_re)) * PW'($signed(coef));
    rnd     = prod + PW'(1 << (DATLEN - 2));
    shifted = rnd >>> (DATLEN - 1);
    if (shifted > SAT_MAX)      win_re = SAT_MAX[DATLEN-1:0];
    else if (shifted < SAT_MIN) win_re = SAT_MIN[DATLEN-1:0];
    else                        win_re = shifted[DATLEN-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_nd    <= 1'b0;
      out_re    <= '0;
      out_idx   <= '0;
      out_start <= 1'b0;
    end else begin
      out_nd <= iss_nd;
      if (iss_nd) begin
        out_re    <= win_re;
        out_idx   <= iss_idx;
        out_start <= iss_start;
      end
    end
  end
`else
  assign out_nd    = iss_nd;
  assign out_re    = iss_re;
  assign out_idx   = iss_idx;
  assign out_start = iss_start;
`endif

  assign fft_nd      = out_nd;
  assign fft_x       = {out_re, {DATLEN{1'b0}}};
  assign frame_idx   = out_idx;
  assign frame_start = out_nd & out_start;

endmodule

// File: tb/tb_ci_adc_framer.sv
// tb/tb_ci_adc_framer.sv - directed self-checking bench for ci_adc_framer (default build)
module tb_ci_adc_framer;

  logic        clk = 1'b0;
  logic        reset_n, run, adc_valid;
  logic [11:0] adc_data;
  logic        adc_ready, fft_nd, frame_start, drop_flag;
  logic [0:23] fft_x;
  logic [3:0]  frame_idx;

  int errors = 0;
  int checks = 0;

  logic [11:0] q_re[$];
  logic [3:0]  q_idx[$];
  logic        q_st[$];
  int          adj = 0;
  logic        prev_nd = 1'b0;

  ci_adc_framer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .adc_ready   (adc_ready),
    .fft_x       (fft_x),
    .fft_nd      (fft_nd),
    .frame_start (frame_start),
    .frame_idx   (frame_idx),
    .drop_flag   (drop_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fft_nd) begin
      q_re.push_back(fft_x[0:11]);
      q_idx.push_back(frame_idx);
      q_st.push_back(frame_start);
      if (prev_nd) adj++;
    end
    prev_nd = fft_nd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_re.delete();
    q_idx.delete();
    q_st.delete();
    adj = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; adc_valid = 1'b0; adc_data = 12'h000;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    clear_log();
    run = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b1; adc_valid = 1'b0; adc_data = 12'h000;
    repeat (2) tick();
    checks++; if (adc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", adc_ready); end
    checks++; if (fft_x !== 24'h0) begin errors++; $display("FAIL reset_fft_x: got %h expected 000000", fft_x); end
    checks++; if (fft_nd !== 1'b0) begin errors++; $display("FAIL reset_nd: got %b expected 0", fft_nd); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", frame_start); end
    checks++; if (frame_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", frame_idx); end
    checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop_flag); end
  endtask

  task automatic test_single();
    do_reset();
    adc_valid = 1'b1; adc_data = 12'hFFF;
    #1;
    checks++; if (adc_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", adc_ready); end
    tick();
    adc_valid = 1'b0;
    checks++; if (fft_nd !== 1'b0) begin errors++; $display("FAIL single_nd_n1: got %b expected 0", fft_nd); end
    tick();
    checks++; if (fft_nd !== 1'b1) begin errors++; $display("FAIL single_nd_n2: got %b expected 1", fft_nd); end
    checks++; if (fft_x !== 24'h7FF000) begin errors++; $display("FAIL single_fft_x: got %h expected 7ff000", fft_x); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", frame_start); end
    checks++; if (frame_idx !== 4'd0) begin errors++; $display("FAIL single_idx: got %0d expected 0", frame_idx); end
    tick();
    checks++; if (fft_nd !== 1'b0) begin errors++; $display("FAIL single_nd_n3: got %b expected 0", fft_nd); end
    checks++; if (fft_x !== 24'h7FF000) begin errors++; $display("FAIL single_hold: got %h expected 7ff000", fft_x); end
    checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL single_drop: got %b expected 0", drop_flag); end
  endtask

  task automatic test_convert();
    logic [11:0] vin [3];
    logic [11:0] vexp [3];
    vin  = '{12'h000, 12'h800, 12'hFFF};
    vexp = '{12'h800, 12'h000, 12'h7FF};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      adc_valid = 1'b1; adc_data = vin[k];
      tick();
      adc_valid = 1'b0;
      repeat (3) tick();
    end
    checks++; if (q_re.size() !== 3) begin errors++; $display("FAIL conv_count: got %0d expected 3", q_re.size()); end
    for (int k = 0; k < 3 && k < q_re.size(); k++) begin
      checks++;
      if ({q_re[k], q_idx[k]} !== {vexp[k], 4'(k)}) begin
        errors++; $display("FAIL conv_word%0d: got re=%h idx=%0d expected re=%h idx=%0d", k, q_re[k], q_idx[k], vexp[k], k);
      end
    end
  endtask

  task automatic test_drain();
    int i, cyc;
    logic acc;
    do_reset();
    i = 0; cyc = 0;
    while (i < 5 && cyc < 100) begin
      adc_valid = 1'b1; adc_data = 12'h801 + 12'(i);
      #1; acc = adc_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    adc_valid = 1'b0;
    run = 1'b0;
    cyc = 0;
    while (q_re.size() < 16 && cyc < 200) begin tick(); cyc++; end
    repeat (10) tick();
    checks++; if (q_re.size() !== 16) begin errors++; $display("FAIL drain_count: got %0d expected 16", q_re.size()); end
    checks++; if (frame_idx !== 4'd15) begin errors++; $display("FAIL drain_last_idx: got %0d expected 15", frame_idx); end
    checks++; if (adj !== 0) begin errors++; $display("FAIL drain_adjacent: got %0d expected 0", adj); end
    checks++; if (adc_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b expected 0", adc_ready); end
    for (int k = 0; k < 16 && k < q_re.size(); k++) begin
      logic [11:0] er;
      er = (k < 5) ? 12'(k + 1) : 12'h000;
      checks++;
      if ({q_re[k], q_idx[k]} !== {er, 4'(k)}) begin
        errors++; $display("FAIL drain_word%0d: got re=%h idx=%0d expected re=%h idx=%0d", k, q_re[k], q_idx[k], er, k);
      end
    end
    run = 1'b1;
    tick();
    adc_valid = 1'b1; adc_data = 12'h8AB;
    tick();
    adc_valid = 1'b0;
    repeat (4) tick();
    checks++; if (q_re.size() !== 17) begin errors++; $display("FAIL drain_restart_count: got %0d expected 17", q_re.size()); end
    if (q_re.size() == 17) begin
      checks++;
      if ({q_re[16], q_idx[16], q_st[16]} !== {12'h0AB, 4'd0, 1'b1}) begin
        errors++; $display("FAIL drain_restart_word: got re=%h idx=%0d st=%b expected re=0ab idx=0 st=1", q_re[16], q_idx[16], q_st[16]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int i, cyc, blocked;
    logic acc;
    do_reset();
    i = 0; cyc = 0; blocked = 0;
    while (i < 32 && cyc < 500) begin
      adc_valid = 1'b1; adc_data = 12'h800 + 12'(i);
      #1; acc = adc_ready;
      if (!acc) blocked++;
      tick();
      if (acc) i++;
      cyc++;
    end
    adc_valid = 1'b0;
    cyc = 0;
    while (q_re.size() < 32 && cyc < 200) begin tick(); cyc++; end
    checks++; if (q_re.size() !== 32) begin errors++; $display("FAIL b2b_count: got %0d expected 32", q_re.size()); end
    checks++; if (adj !== 0) begin errors++; $display("FAIL b2b_adjacent: got %0d expected 0", adj); end
    checks++; if (blocked == 0) begin errors++; $display("FAIL b2b_backpressure: got %0d blocked cycles expected >0", blocked); end
    checks++; if (drop_flag !== (blocked != 0)) begin errors++; $display("FAIL b2b_drop: got %b expected %b", drop_flag, blocked != 0); end
    for (int k = 0; k < 32 && k < q_re.size(); k++) begin
      checks++;
      if ({q_re[k], q_idx[k], q_st[k]} !== {12'(k), 4'(k % 16), 1'(k % 16 == 0)}) begin
        errors++; $display("FAIL b2b_word%0d: got re=%h idx=%0d st=%b expected re=%h idx=%0d st=%b",
                           k, q_re[k], q_idx[k], q_st[k], 12'(k), k % 16, k % 16 == 0);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int cyc;
    logic [3:0] pre_idx;
    do_reset();
    cyc = 0;
    while (q_re.size() < 8 && cyc < 200) begin
      adc_valid = 1'b1; adc_data = 12'h900;
      tick();
      cyc++;
    end
    adc_valid = 1'b0;
    pre_idx = frame_idx;
    checks++; if (pre_idx !== 4'd7) begin errors++; $display("FAIL mid_pre_idx: got %0d expected 7", pre_idx); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({fft_x, fft_nd, frame_start, frame_idx, adc_ready, drop_flag} !== 32'h0) begin
      errors++; $display("FAIL mid_async_clear: got x=%h nd=%b st=%b idx=%0d rdy=%b drop=%b expected all 0",
                         fft_x, fft_nd, frame_start, frame_idx, adc_ready, drop_flag);
    end
    tick();
    reset_n = 1'b1;
    tick();
    clear_log();
    tick();
    adc_valid = 1'b1; adc_data = 12'h805;
    tick();
    adc_valid = 1'b0;
    repeat (4) tick();
    checks++; if (q_re.size() !== 1) begin errors++; $display("FAIL mid_after_count: got %0d expected 1", q_re.size()); end
    if (q_re.size() == 1) begin
      checks++;
      if ({q_re[0], q_idx[0], q_st[0]} !== {12'h005, 4'd0, 1'b1}) begin
        errors++; $display("FAIL mid_after_word: got re=%h idx=%0d st=%b expected re=005 idx=0 st=1", q_re[0], q_idx[0], q_st[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_convert();
    test_drain();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
